// File: rtl/sa_result_drain.sv
// Drains a systolic array: deskews the staggered column results into aligned rows
// and queues them in a small register FIFO with row/matrix bookkeeping for the consumer.
module sa_result_drain #(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int ROWS  = 4,
  parameter int CW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N*W-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          overflow,
  output logic [CW-1:0] row_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C  = DEPTH[AW:0];
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

  logic [N*W-1:0] aligned_row;
  logic           row_valid;

  // Column gi waits N-1-gi cycles so every column of a row lines up with the last one.
  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_col
    localparam int STG = N - 1 - gi;
    if (STG == 0) begin : g_pass
      assign aligned_row[gi*W +: W] = in_data[gi*W +: W];
    end else begin : g_dly
      logic [W-1:0] stg_q [STG];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < STG; s++) stg_q[s] <= '0;
        end else if (clr) begin
          for (int s = 0; s < STG; s++) stg_q[s] <= '0;
        end else begin
          stg_q[0] <= in_data[gi*W +: W];
          for (int s = 1; s < STG; s++) stg_q[s] <= stg_q[s-1];
        end
      end
      assign aligned_row[gi*W +: W] = stg_q[STG-1];
    end
  end

  if (N > 1) begin : g_vld
    logic [N-2:0] vld_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q <= '0;
      end else if (clr) begin
        vld_q <= '0;
      end else if (N > 2) begin
        vld_q <= {vld_q, in_valid};
      end else begin
        vld_q <= in_valid;
      end
    end
    assign row_valid = vld_q[N-2];
  end else begin : g_novld
    assign row_valid = in_valid;
  end

  logic [N*W-1:0] mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [CW-1:0]  row_cnt_q, row_cnt_d;
  logic           overflow_q, overflow_d;
  logic           full, pop, push, drop;

  assign full      = (count_q == DEPTH_C);
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign out_last  = out_valid && (row_cnt_q == LAST_ROW);
  assign row_cnt   = row_cnt_q;
  assign overflow  = overflow_q;

  always_comb begin
    pop        = out_valid && out_ready;
    // A full FIFO still takes the row when the consumer frees a slot this cycle.
    push       = row_valid && (!full || pop);
    drop       = row_valid && full && !pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    row_cnt_d  = row_cnt_q;
    overflow_d = overflow_q || drop;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      row_cnt_d = out_last ? '0 : row_cnt_q + CW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      row_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      row_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      row_cnt_q  <= row_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is cleared too so out_data reads zero until the first row lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= aligned_row;
    end
  end

endmodule

// File: tb/tb_sa_result_drain.sv
// Scoreboard bench for sa_result_drain: drives skewed rows, models alignment and the FIFO.
module tb_sa_result_drain;
  localparam int N = 4, W = 16, DEPTH = 4, ROWS = 4, CW = 2, NW = N * W, MAXC = 4096;

  logic          clk = 1'b0;
  logic          rst, clr, in_valid, out_ready, out_valid, out_last, overflow;
  logic [NW-1:0] in_data, out_data;
  logic [CW-1:0] row_cnt;

  always #5 clk = ~clk;

  sa_result_drain #(.N(N), .W(W), .DEPTH(DEPTH), .ROWS(ROWS), .CW(CW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .overflow(overflow), .row_cnt(row_cnt)
  );

  int            total = 0, bad = 0, cyc = 0;
  logic          hv [MAXC];
  logic [NW-1:0] hr [MAXC];
  logic [NW-1:0] mq [$];
  int            mrow = 0;
  logic          movf = 1'b0, pushed = 1'b0;

  task automatic check_val(input string tag, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [NW-1:0] rnd_row();
    return {$urandom, $urandom};
  endfunction

  task automatic check_outputs();
    logic ev;
    ev = (mq.size() > 0);
    check_val("out_valid", out_valid, ev);
    if (ev) check_val("out_data", out_data, mq[0]);
    else if (!pushed) check_val("out_data_zero", out_data, '0);
    check_val("out_last", out_last, ev && (mrow == ROWS - 1));
    check_val("row_cnt", row_cnt, mrow);
    check_val("overflow", overflow, movf);
  endtask

  // One cycle: check the state seen now, drive inputs, advance the model past the next edge.
  task automatic step(input logic v, input logic [NW-1:0] row, input logic rdy, input logic c);
    logic          pop, algn;
    logic [NW-1:0] d, tmp;
    check_outputs();
    hv[cyc] = v;
    hr[cyc] = row;
    d = rnd_row();
    d[W-1:0] = row[W-1:0];
    for (int k = 1; k < N; k++)
      if (cyc - k >= 0) d[k*W +: W] = hr[cyc-k][k*W +: W];
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    clr       = c;
    pop  = (mq.size() > 0) && rdy;
    algn = (cyc >= N - 1) && hv[cyc-(N-1)];
    if (c) begin
      mq.delete();
      mrow = 0; movf = 1'b0; pushed = 1'b0;
      for (int j = 0; j < N - 1; j++) if (cyc - j >= 0) hv[cyc-j] = 1'b0;
    end else begin
      if (pop) begin
        tmp = mq.pop_front();
        mrow = (mrow == ROWS - 1) ? 0 : mrow + 1;
      end
      if (algn) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(hr[cyc-(N-1)]);
          pushed = 1'b1;
        end else begin
          movf = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, rnd_row(), rdy, 1'b0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    check_val("arst_out_valid", out_valid, 1'b0);
    check_val("arst_out_data", out_data, '0);
    check_val("arst_out_last", out_last, 1'b0);
    check_val("arst_overflow", overflow, 1'b0);
    check_val("arst_row_cnt", row_cnt, '0);
    in_valid = 1'b0;
    clr      = 1'b0;
    hv[cyc]  = 1'b0;
    hr[cyc]  = rnd_row();
    for (int j = 1; j < N; j++) if (cyc - j >= 0) hv[cyc-j] = 1'b0;
    mq.delete();
    mrow = 0; movf = 1'b0; pushed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < MAXC; i++) hv[i] = 1'b0;
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b1;
    cyc = 0;

    // single skewed row, visible N cycles after its column 0
    step(1'b1, 64'h0044_0033_0022_0011, 1'b1, 1'b0);
    idle(6, 1'b1);

    // back-to-back matrix
    for (int i = 0; i < 4; i++) step(1'b1, rnd_row(), 1'b1, 1'b0);
    idle(8, 1'b1);

    // backpressure with one row too many
    for (int i = 0; i < 5; i++) step(1'b1, rnd_row(), 1'b0, 1'b0);
    idle(6, 1'b0);
    idle(8, 1'b1);

    // full FIFO with push and pop together
    step(1'b0, rnd_row(), 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, rnd_row(), (i >= 7), 1'b0);
    idle(8, 1'b1);

    // flush with rows queued and one in the deskew
    step(1'b1, rnd_row(), 1'b0, 1'b0);
    step(1'b1, rnd_row(), 1'b0, 1'b0);
    idle(3, 1'b0);
    step(1'b1, rnd_row(), 1'b0, 1'b0);
    step(1'b0, rnd_row(), 1'b0, 1'b1);
    idle(8, 1'b1);

    // flush mid-matrix restarts row numbering
    for (int i = 0; i < 2; i++) step(1'b1, rnd_row(), 1'b1, 1'b0);
    idle(5, 1'b1);
    step(1'b0, rnd_row(), 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, rnd_row(), 1'b1, 1'b0);
    idle(8, 1'b1);

    // random traffic
    for (int i = 0; i < 300; i++)
      step(1'(($urandom_range(0, 1))), rnd_row(), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 40) == 0));
    idle(8, 1'b1);

    // asynchronous reset with rows queued mid-matrix
    for (int i = 0; i < 3; i++) step(1'b1, rnd_row(), (i == 0), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, rnd_row(), 1'b0, 1'b0);
    async_reset();
    for (int i = 0; i < 4; i++) step(1'b1, rnd_row(), 1'b1, 1'b0);
    idle(8, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
